// File: rtl/prog_bus_pkg.sv
// Shared types for the programmer/CPU bus arbiter:
// state encoding, requester indices and read-latency bound.
package prog_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT
  } bus_state_t;

  localparam logic CPU = 1'b0;
  localparam logic PRG = 1'b1;

  localparam int RD_LAT_MAX = 3;
  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/prog_bus_rr2.sv
// Two-way pick between CPU and programmer requests,
// honouring programmer lock and fixed-priority mode.
module prog_bus_rr2
  import prog_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  input  logic       prio,
  output logic       valid,
  output logic       winner
);

  logic cpu_ok;
  logic tie;

  // A locked programmer that owns the bus shuts the CPU out.
  assign cpu_ok = req[CPU] & ~(lock & (last == PRG));
  assign tie    = cpu_ok & req[PRG];
  assign valid  = cpu_ok | req[PRG];

  always_comb begin
    winner = CPU;
    unique case (1'b1)
      tie:                winner = prio ? PRG : ~last;
      !cpu_ok & req[PRG]: winner = PRG;
      default:            winner = CPU;
    endcase
  end

endmodule

// File: rtl/prog_bus_arbiter.sv
// Arbitrates the Open8 bus between the CPU and the
// SPI programmer; single outstanding transfer.
module prog_bus_arbiter
  import prog_bus_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int PRG_PRIO = 0
) (
  input  logic        clk,
  input  logic        i_nrst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        prg_req,
  input  logic        prg_we,
  input  logic [15:0] prg_addr,
  input  logic [7:0]  prg_wdata,
  input  logic        prg_lock,
  output logic        prg_gnt,
  output logic        prg_rvalid,
  output logic [7:0]  prg_rdata,
  input  logic        i_cpu_reset,
  output logic [15:0] o_Address,
  output logic [7:0]  o_Wr_Data,
  output logic        o_Wr_En,
  output logic        o_Rd_En,
  input  logic [7:0]  i_Rd_Data,
  output logic        o_busy
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);

  bus_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, last_n;

  logic [1:0]  req;
  logic        arb_vld;
  logic        arb_win;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;

  logic [15:0] addr_n;
  logic [7:0]  wdata_n;
  logic [7:0]  crd_n, prd_n;
  logic        wr_n, rd_n;
  logic        cgnt_n, pgnt_n;
  logic        cval_n, pval_n;

  assign req = {prg_req, cpu_req & ~i_cpu_reset};

  assign sel_we    = arb_win ? prg_we    : cpu_we;
  assign sel_addr  = arb_win ? prg_addr  : cpu_addr;
  assign sel_wdata = arb_win ? prg_wdata : cpu_wdata;

  prog_bus_rr2 u_rr2 (
    .req    (req),
    .last   (last),
    .lock   (prg_lock),
    .prio   (PRG_PRIO != 0),
    .valid  (arb_vld),
    .winner (arb_win)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    addr_n  = o_Address;
    wdata_n = o_Wr_Data;
    crd_n   = cpu_rdata;
    prd_n   = prg_rdata;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    cgnt_n  = 1'b0;
    pgnt_n  = 1'b0;
    cval_n  = 1'b0;
    pval_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_vld) begin
          last_n  = arb_win;
          addr_n  = sel_addr;
          wdata_n = sel_wdata;
          cgnt_n  = (arb_win == CPU);
          pgnt_n  = (arb_win == PRG);
          wr_n    = sel_we;
          rd_n    = ~sel_we;
          state_n = sel_we ? WRITE : READ;
        end
      end
      WRITE: state_n = IDLE;
      READ: begin
        state_n = RWAIT;
        cnt_n   = CNT_W'(1);
      end
      RWAIT: begin
        // last still names the owner of the read
        if (cnt == LAT) begin
          state_n = IDLE;
          cval_n  = (last == CPU);
          pval_n  = (last == PRG);
          if (last == PRG) prd_n = i_Rd_Data;
          else             crd_n = i_Rd_Data;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= PRG;
      o_Address  <= '0;
      o_Wr_Data  <= '0;
      o_Wr_En    <= 1'b0;
      o_Rd_En    <= 1'b0;
      cpu_gnt    <= 1'b0;
      prg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      prg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      prg_rdata  <= '0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last       <= last_n;
      o_Address  <= addr_n;
      o_Wr_Data  <= wdata_n;
      o_Wr_En    <= wr_n;
      o_Rd_En    <= rd_n;
      cpu_gnt    <= cgnt_n;
      prg_gnt    <= pgnt_n;
      cpu_rvalid <= cval_n;
      prg_rvalid <= pval_n;
      cpu_rdata  <= crd_n;
      prg_rdata  <= prd_n;
      o_busy     <= (state_n != IDLE);
    end
  end

endmodule
